// File: rtl/instruction_decode_if.sv
// -----------------------------------------------------------------------------
// instruction_decode_if
// Bundles the decode stage's fetch-side inputs, hazard controls, write-back
// port and execute-side outputs. Clock and reset stay outside as plain ports.
//   master : upstream / environment side (drives d_i_*, observes d_o_*)
//   slave  : decode stage side (observes d_i_*, drives d_o_*)
// -----------------------------------------------------------------------------
interface instruction_decode_if #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5
);
  // fetch side
  logic                d_i_ce;
  logic [IWIDTH-1:0]   d_i_instr;
  logic [PC_WIDTH-1:0] d_i_pc;
  // hazard control
  logic                d_i_stall;
  logic                d_i_flush;
  // write-back
  logic                d_i_we;
  logic [AWIDTH-1:0]   d_i_waddr;
  logic [DWIDTH-1:0]   d_i_wdata;
  // execute side
  logic                d_o_ce;
  logic [PC_WIDTH-1:0] d_o_pc;
  logic [5:0]          d_o_opcode;
  logic [5:0]          d_o_funct;
  logic [4:0]          d_o_shamt;
  logic [AWIDTH-1:0]   d_o_rs_addr;
  logic [AWIDTH-1:0]   d_o_rt_addr;
  logic [AWIDTH-1:0]   d_o_rd_addr;
  logic [DWIDTH-1:0]   d_o_rs_data;
  logic [DWIDTH-1:0]   d_o_rt_data;
  logic [DWIDTH-1:0]   d_o_imm;
  logic                d_o_reg_write;
  logic                d_o_mem_read;
  logic                d_o_mem_write;
  logic                d_o_alu_src;
  logic                d_o_mem_to_reg;
  logic                d_o_link;
  // redirect to fetch
  logic                d_o_change_pc;
  logic [PC_WIDTH-1:0] d_o_pc_target;
  logic                d_o_illegal;

  modport master (
    output d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_flush,
           d_i_we, d_i_waddr, d_i_wdata,
    input  d_o_ce, d_o_pc, d_o_opcode, d_o_funct, d_o_shamt,
           d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_rs_data, d_o_rt_data,
           d_o_imm, d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_alu_src,
           d_o_mem_to_reg, d_o_link, d_o_change_pc, d_o_pc_target, d_o_illegal
  );

  modport slave (
    input  d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_flush,
           d_i_we, d_i_waddr, d_i_wdata,
    output d_o_ce, d_o_pc, d_o_opcode, d_o_funct, d_o_shamt,
           d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_rs_data, d_o_rt_data,
           d_o_imm, d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_alu_src,
           d_o_mem_to_reg, d_o_link, d_o_change_pc, d_o_pc_target, d_o_illegal
  );
endinterface

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// MIPS decode stage. Splits instruction fields, generates control bits, reads
// the 32x32 register file (with same-cycle write-back bypass), resolves jumps
// and branches into a one-cycle redirect pulse, and registers everything into
// a single pipeline stage towards execute.
// Ports:
//   d_clk  : clock, rising edge
//   d_rst  : synchronous active-low reset (clears outputs and register file)
//   bus    : instruction_decode_if.slave (fetch inputs, stall/flush,
//            write-back port, execute outputs, redirect, illegal pulse)
// -----------------------------------------------------------------------------
module instruction_decode #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5
) (
  input  logic                 d_clk,
  input  logic                 d_rst,
  instruction_decode_if.slave  bus
);

  localparam int NREGS = 1 << AWIDTH;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // register file
  logic [DWIDTH-1:0] rf_q [NREGS];

  // field split
  logic [5:0]          opcode;
  logic [AWIDTH-1:0]   rs_addr;
  logic [AWIDTH-1:0]   rt_addr;
  logic [AWIDTH-1:0]   rd_field;
  logic [DWIDTH-1:0]   rs_data;
  logic [DWIDTH-1:0]   rt_data;
  logic [DWIDTH-1:0]   sext_imm;
  logic [DWIDTH-1:0]   zext_imm;
  logic [DWIDTH-1:0]   lui_imm;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;

  assign opcode   = bus.d_i_instr[31:26];
  assign rs_addr  = AWIDTH'(bus.d_i_instr[25:21]);
  assign rt_addr  = AWIDTH'(bus.d_i_instr[20:16]);
  assign rd_field = AWIDTH'(bus.d_i_instr[15:11]);

  assign sext_imm = {{(DWIDTH-16){bus.d_i_instr[15]}}, bus.d_i_instr[15:0]};
  assign zext_imm = DWIDTH'(bus.d_i_instr[15:0]);
  assign lui_imm  = DWIDTH'({bus.d_i_instr[15:0], 16'h0000});

  // PC arithmetic wraps naturally at PC_WIDTH bits
  assign pc_plus4      = bus.d_i_pc + PC_WIDTH'(4);
  assign branch_target = pc_plus4 +
                         {{(PC_WIDTH-18){bus.d_i_instr[15]}}, bus.d_i_instr[15:0], 2'b00};
  assign jump_target   = {pc_plus4[PC_WIDTH-1:28], bus.d_i_instr[25:0], 2'b00};

  // Register reads: R0 is hard zero; a write landing this edge is forwarded so
  // the decoded operands never see stale data.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0)
      rs_data = (bus.d_i_we && bus.d_i_waddr == rs_addr) ? bus.d_i_wdata : rf_q[rs_addr];
    if (rt_addr != '0)
      rt_data = (bus.d_i_we && bus.d_i_waddr == rt_addr) ? bus.d_i_wdata : rf_q[rt_addr];
  end

  // control decode
  logic                ce_d;
  logic                illegal_d;
  logic                reg_write_d;
  logic                mem_read_d;
  logic                mem_write_d;
  logic                alu_src_d;
  logic                mem_to_reg_d;
  logic                link_d;
  logic                change_pc_d;
  logic [AWIDTH-1:0]   rd_addr_d;
  logic [DWIDTH-1:0]   imm_d;
  logic [PC_WIDTH-1:0] pc_target_d;

  always_comb begin
    ce_d         = 1'b1;
    illegal_d    = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    link_d       = 1'b0;
    change_pc_d  = 1'b0;
    rd_addr_d    = rt_addr;
    imm_d        = sext_imm;
    pc_target_d  = branch_target;
    case (opcode)
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        rd_addr_d   = rd_field;
      end
      OP_ADDI, OP_SLTI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = zext_imm;
      end
      OP_LUI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = lui_imm;
      end
      OP_LW: begin
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_BEQ: change_pc_d = (rs_data == rt_data);
      OP_BNE: change_pc_d = (rs_data != rt_data);
      OP_J: begin
        change_pc_d = 1'b1;
        pc_target_d = jump_target;
      end
      OP_JAL: begin
        change_pc_d = 1'b1;
        pc_target_d = jump_target;
        reg_write_d = 1'b1;
        link_d      = 1'b1;
        rd_addr_d   = AWIDTH'(31);
      end
      default: begin
        ce_d      = 1'b0;
        illegal_d = 1'b1;
      end
    endcase
  end

  // output stage registers
  logic                ce_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [5:0]          opcode_q;
  logic [5:0]          funct_q;
  logic [4:0]          shamt_q;
  logic [AWIDTH-1:0]   rs_addr_q;
  logic [AWIDTH-1:0]   rt_addr_q;
  logic [AWIDTH-1:0]   rd_addr_q;
  logic [DWIDTH-1:0]   rs_data_q;
  logic [DWIDTH-1:0]   rt_data_q;
  logic [DWIDTH-1:0]   imm_q;
  logic                reg_write_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                alu_src_q;
  logic                mem_to_reg_q;
  logic                link_q;
  logic                change_pc_q;
  logic [PC_WIDTH-1:0] pc_target_q;
  logic                illegal_q;

  // ---- decode -> execute stage boundary ----
  always_ff @(posedge d_clk) begin
    if (!d_rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      ce_q         <= 1'b0;
      pc_q         <= '0;
      opcode_q     <= '0;
      funct_q      <= '0;
      shamt_q      <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      change_pc_q  <= 1'b0;
      pc_target_q  <= '0;
      illegal_q    <= 1'b0;
    end else begin
      // write-back proceeds regardless of stall/flush
      if (bus.d_i_we && bus.d_i_waddr != '0)
        rf_q[bus.d_i_waddr] <= bus.d_i_wdata;

      if (bus.d_i_flush || !bus.d_i_ce) begin
        // bubble: data fields keep stale values, only control is cleared
        ce_q         <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        alu_src_q    <= 1'b0;
        mem_to_reg_q <= 1'b0;
        link_q       <= 1'b0;
        change_pc_q  <= 1'b0;
        illegal_q    <= 1'b0;
      end else if (bus.d_i_stall) begin
        // hold everything but the pulses, so a redirect fires only once
        change_pc_q <= 1'b0;
        illegal_q   <= 1'b0;
      end else begin
        ce_q         <= ce_d;
        pc_q         <= bus.d_i_pc;
        opcode_q     <= opcode;
        funct_q      <= bus.d_i_instr[5:0];
        shamt_q      <= bus.d_i_instr[10:6];
        rs_addr_q    <= rs_addr;
        rt_addr_q    <= rt_addr;
        rd_addr_q    <= rd_addr_d;
        rs_data_q    <= rs_data;
        rt_data_q    <= rt_data;
        imm_q        <= imm_d;
        reg_write_q  <= reg_write_d;
        mem_read_q   <= mem_read_d;
        mem_write_q  <= mem_write_d;
        alu_src_q    <= alu_src_d;
        mem_to_reg_q <= mem_to_reg_d;
        link_q       <= link_d;
        change_pc_q  <= change_pc_d;
        pc_target_q  <= pc_target_d;
        illegal_q    <= illegal_d;
      end
    end
  end

  assign bus.d_o_ce         = ce_q;
  assign bus.d_o_pc         = pc_q;
  assign bus.d_o_opcode     = opcode_q;
  assign bus.d_o_funct      = funct_q;
  assign bus.d_o_shamt      = shamt_q;
  assign bus.d_o_rs_addr    = rs_addr_q;
  assign bus.d_o_rt_addr    = rt_addr_q;
  assign bus.d_o_rd_addr    = rd_addr_q;
  assign bus.d_o_rs_data    = rs_data_q;
  assign bus.d_o_rt_data    = rt_data_q;
  assign bus.d_o_imm        = imm_q;
  assign bus.d_o_reg_write  = reg_write_q;
  assign bus.d_o_mem_read   = mem_read_q;
  assign bus.d_o_mem_write  = mem_write_q;
  assign bus.d_o_alu_src    = alu_src_q;
  assign bus.d_o_mem_to_reg = mem_to_reg_q;
  assign bus.d_o_link       = link_q;
  assign bus.d_o_change_pc  = change_pc_q;
  assign bus.d_o_pc_target  = pc_target_q;
  assign bus.d_o_illegal    = illegal_q;

endmodule
